// File: rtl/eth_mac_rx_addr_filter.sv
// Receive-side destination address filter: holds the 6-byte DA, decides pass/drop,
// then streams accepted frames with a fixed 6-byte lag and drains the lag at end of frame.
module eth_mac_rx_addr_filter (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] cfg_mac_addr,
  input  logic        cfg_promisc,
  input  logic        cfg_bcast_enable,
  input  logic        cfg_mcast_enable,
  output logic        stat_pass,
  output logic        stat_drop,
  output logic        stat_overflow
);
  typedef enum logic [1:0] {HDR, PASS, DROP, FLUSH} state_t;

  state_t          state, state_nx;
  logic [5:0][7:0] hbuf;        // hbuf[0] is the oldest byte
  logic [2:0]      cnt, cnt_nx; // header write index in HDR, drain count in FLUSH
  logic            tuser_q, tuser_nx;
  logic            mid_q, mid_nx; // an overflowing frame is still in progress during FLUSH
  logic            wr_hdr, shift;
  logic            o_vld, o_last, o_user;
  logic            p_pass, p_drop, p_ovf;
  logic            in_frame;

  logic [47:0] da;
  logic        is_bcast, is_mcast, match;
  assign da       = {hbuf[0], hbuf[1], hbuf[2], hbuf[3], hbuf[4], s_axis_tdata};
  assign is_bcast = (da == 48'hFFFF_FFFF_FFFF);
  assign is_mcast = !is_bcast && da[40];
  assign match    = cfg_promisc || (is_bcast && cfg_bcast_enable) ||
                    (is_mcast && cfg_mcast_enable) || (da == cfg_mac_addr);
  assign in_frame = s_axis_tvalid ? !s_axis_tlast : mid_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tuser_nx = tuser_q;
    mid_nx   = mid_q;
    wr_hdr   = 1'b0;
    shift    = 1'b0;
    o_vld    = 1'b0;
    o_last   = 1'b0;
    o_user   = 1'b0;
    p_pass   = 1'b0;
    p_drop   = 1'b0;
    p_ovf    = 1'b0;
    case (state)
      HDR: if (s_axis_tvalid) begin
        wr_hdr = 1'b1;
        if (cnt == 3'd5) begin
          cnt_nx = '0;
          if (match) begin
            p_pass = 1'b1;
            if (s_axis_tlast) begin
              state_nx = FLUSH;
              tuser_nx = s_axis_tuser;
            end else begin
              state_nx = PASS;
            end
          end else begin
            p_drop   = 1'b1;
            state_nx = s_axis_tlast ? HDR : DROP;
          end
        end else if (s_axis_tlast) begin
          p_drop = 1'b1;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      PASS: if (s_axis_tvalid) begin
        shift = 1'b1;
        o_vld = 1'b1;
        if (s_axis_tlast) begin
          state_nx = FLUSH;
          tuser_nx = s_axis_tuser;
          cnt_nx   = '0;
        end
      end
      DROP: if (s_axis_tvalid && s_axis_tlast) begin
        state_nx = HDR;
        cnt_nx   = '0;
      end
      FLUSH: begin
        shift = 1'b1;
        o_vld = 1'b1;
        // anything arriving now is a new frame that cannot be buffered
        if (s_axis_tvalid && !mid_q) p_ovf = 1'b1;
        if (cnt == 3'd5) begin
          o_last   = 1'b1;
          o_user   = tuser_q;
          cnt_nx   = '0;
          mid_nx   = 1'b0;
          state_nx = in_frame ? DROP : HDR;
        end else begin
          cnt_nx = cnt + 3'd1;
          mid_nx = in_frame;
        end
      end
      default: state_nx = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR;
      cnt           <= '0;
      hbuf          <= '0;
      tuser_q       <= 1'b0;
      mid_q         <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      stat_pass     <= 1'b0;
      stat_drop     <= 1'b0;
      stat_overflow <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tuser_q <= tuser_nx;
      mid_q   <= mid_nx;
      if (wr_hdr)     hbuf[cnt] <= s_axis_tdata;
      else if (shift) hbuf      <= {s_axis_tdata, hbuf[5:1]};
      m_axis_tdata  <= hbuf[0];
      m_axis_tvalid <= o_vld;
      m_axis_tlast  <= o_last;
      m_axis_tuser  <= o_user;
      stat_pass     <= p_pass;
      stat_drop     <= p_drop;
      stat_overflow <= p_ovf;
    end
  end
endmodule

// File: tb/tb_eth_mac_rx_addr_filter.sv
// Scoreboard bench: expected output beats (data/last/user/cycle) queued as frames are driven.
module tb_eth_mac_rx_addr_filter;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [47:0] cfg_mac_addr = 48'h02_00_00_00_00_01;
  logic cfg_promisc = 1'b0, cfg_bcast_enable = 1'b0, cfg_mcast_enable = 1'b0;
  logic stat_pass, stat_drop, stat_overflow;

  eth_mac_rx_addr_filter dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cfg_mac_addr(cfg_mac_addr), .cfg_promisc(cfg_promisc),
    .cfg_bcast_enable(cfg_bcast_enable), .cfg_mcast_enable(cfg_mcast_enable),
    .stat_pass(stat_pass), .stat_drop(stat_drop), .stat_overflow(stat_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         c;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  cyc = 0;
  int  n_chk = 0, n_pass = 0;
  int  n_sp = 0, n_sd = 0, n_so = 0;
  int  b_sp = 0, b_sd = 0, b_so = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (stat_pass)     n_sp++;
    if (stat_drop)     n_sd++;
    if (stat_overflow) n_so++;
    if (!rst && m_axis_tvalid) begin
      if (sb.size() == 0) check("extra_beat", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("data",  m_axis_tdata, mon_e.d);
        check("tlast", m_axis_tlast, mon_e.l);
        check("tuser", m_axis_tuser, mon_e.u);
        check("cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one frame; beats separated by gap idle cycles. abort_at>=0 asserts rst instead of that beat.
  task automatic send(input logic [47:0] da, input int len, input bit tu, input int gap,
                      input bit exp_pass, input int abort_at);
    logic [7:0] b[$];
    for (int k = 0; k < len; k++) b.push_back(k < 6 ? da[47-8*k -: 8] : 8'($urandom));
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        idle(0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata",  m_axis_tdata, 0);
        check("rst_tlast",  m_axis_tlast, 0);
        rst = 1'b0;
        return;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b[k];
      s_axis_tlast  = (k == len - 1);
      s_axis_tuser  = (k == len - 1) ? tu : 1'b0;
      if (exp_pass) begin
        if (k >= 6) sb.push_back('{d: b[k-6], l: 1'b0, u: 1'b0, c: cyc + 1});
        if (k == len - 1)
          for (int i = 0; i < 6; i++)
            sb.push_back('{d: b[len-6+i], l: (i == 5), u: (i == 5) ? tu : 1'b0, c: cyc + 2 + i});
      end
      @(posedge clk); #1;
      if (k != len - 1) idle(gap);
    end
    idle(0);
  endtask

  task automatic stats_chk(input string tag, input int p, input int d, input int o);
    idle(12);
    check({tag, "_drain"}, sb.size(), 0);
    check({tag, "_pass"},  n_sp - b_sp, p);
    check({tag, "_drop"},  n_sd - b_sd, d);
    check({tag, "_ovf"},   n_so - b_so, o);
    b_sp = n_sp; b_sd = n_sd; b_so = n_so;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata",  m_axis_tdata, 0);
    check("rst_tlast",  m_axis_tlast, 0);
    check("rst_tuser",  m_axis_tuser, 0);
    check("rst_stats",  {stat_pass, stat_drop, stat_overflow}, 0);
    rst = 1'b0;
    idle(2);

    send(48'h02_00_00_00_00_01, 64, 1'b0, 0, 1'b1, -1);
    stats_chk("ucast64", 1, 0, 0);

    cfg_mcast_enable = 1'b1;
    send(48'hFF_FF_FF_FF_FF_FF, 60, 1'b0, 0, 1'b0, -1);
    stats_chk("bcast_off", 0, 1, 0);
    cfg_bcast_enable = 1'b1;
    send(48'hFF_FF_FF_FF_FF_FF, 60, 1'b0, 0, 1'b1, -1);
    stats_chk("bcast_on", 1, 0, 0);

    send(48'h01_00_5E_00_00_01, 40, 1'b1, 0, 1'b1, -1);
    stats_chk("mcast_tuser", 1, 0, 0);
    cfg_mcast_enable = 1'b0;
    send(48'h01_00_5E_00_00_01, 30, 1'b0, 0, 1'b0, -1);
    stats_chk("mcast_off", 0, 1, 0);

    send(48'h02_00_00_00_00_01, 4, 1'b0, 0, 1'b0, -1);
    stats_chk("runt4", 0, 1, 0);
    send(48'h02_00_00_00_00_01, 6, 1'b1, 0, 1'b1, -1);
    stats_chk("min6", 1, 0, 0);
    send(48'h02_00_00_00_00_02, 6, 1'b0, 0, 1'b0, -1);
    stats_chk("min6_miss", 0, 1, 0);

    send(48'h0A_0B_0C_0D_0E_0F, 25, 1'b0, 0, 1'b0, -1);
    stats_chk("ucast_miss", 0, 1, 0);
    cfg_promisc = 1'b1;
    send(48'h0A_0B_0C_0D_0E_0F, 25, 1'b0, 0, 1'b1, -1);
    stats_chk("promisc", 1, 0, 0);
    cfg_promisc = 1'b0;

    send(48'h02_00_00_00_00_01, 20, 1'b0, 0, 1'b1, -1);
    idle(2);
    send(48'h02_00_00_00_00_01, 20, 1'b0, 0, 1'b0, -1);
    stats_chk("overflow", 1, 0, 1);

    send(48'h02_00_00_00_00_01, 64, 1'b0, 1, 1'b1, -1);
    stats_chk("mii64", 1, 0, 0);
    send(48'h02_00_00_00_00_01, 64, 1'b0, 1, 1'b1, 30);
    stats_chk("mii_abort", 1, 0, 0);
    send(48'h02_00_00_00_00_01, 64, 1'b1, 1, 1'b1, -1);
    stats_chk("after_rst", 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
